add32_sched: RTL and testbench
==============================

ADD32_SCHED -- requirements
Module: add32_sched

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin  in/out/in/in/in  1/1/32/32/1  requester 1, same meaning as requester 0.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_sum  output  32  result sum.
REQ-012 rsp_cout  output  1  result carry-out.
REQ-013 rsp_id  output  1  requester that owns the result.
REQ-014 add_in1, add_in2  output  16 each  operands to the shared external 16-bit combinational adder.
REQ-015 add_cin  output  1  carry-in to the shared adder.
REQ-016 add_out  input  16  shared adder sum.
REQ-017 add_cout  input  1  shared adder carry-out.

Function
REQ-018 SHALL implement the FSM states IDLE, LO, HI and RESP.
REQ-019 IDLE: the grant SHALL be computed combinationally; a single valid requester wins; if both are valid, the requester not granted last wins.
REQ-020 req0_ready and req1_ready SHALL assert only in IDLE, only for the granted requester, and only while its valid is high.
REQ-021 At most one ready SHALL be high in any cycle.
REQ-022 On acceptance (valid & ready), the block SHALL latch a, b, cin and id, update last_grant, and go to LO.
REQ-023 LO: the block SHALL drive add_in1=a[15:0], add_in2=b[15:0], add_cin=cin, capture add_out into sum[15:0] and add_cout into a carry register, then go to HI.
REQ-024 HI: the block SHALL drive add_in1=a[31:16], add_in2=b[31:16], add_cin=the carry register, capture add_out into sum[31:16] and add_cout into cout, then go to RESP.
REQ-025 In IDLE and RESP, add_in1, add_in2 and add_cin SHALL be driven to 0.
REQ-026 RESP: rsp_valid SHALL be 1, and rsp_sum, rsp_cout and rsp_id SHALL stay stable until rsp_ready is sampled high; the block then goes to IDLE.
REQ-027 rsp_valid SHALL assert on the 3rd rising edge after the acceptance edge; back-to-back throughput SHALL be 1 operation per 4 cycles with rsp_ready held high.
REQ-028 Result SHALL equal (a + b + cin) mod 2^32; cout SHALL be bit 32 of the full sum.
REQ-029 Wrap-around: 0xFFFFFFFF + 0 + 1 SHALL give sum 0x00000000 with cout 1.
REQ-030 rsp_ready held low SHALL stall indefinitely in RESP; no request is accepted while stalled.
REQ-031 A requester dropping valid before acceptance SHALL lose nothing; requests are not queued.
REQ-032 Operand inputs SHALL be ignored outside the acceptance cycle.

Reset
REQ-033 While rst_n is low: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=1 (so requester 0 wins first), carry=0, and all operand registers=0.
REQ-034 rst_n asserting mid-operation (LO, HI or RESP) SHALL abort the operation immediately, with no response produced after release.
REQ-035 The first acceptance SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-036 Single op: req0 with a=0x00010001, b=0x0000FFFF, cin=0, rsp_ready=1 -> rsp_valid 3 edges after accept; rsp_sum=0x00020000, cout=0, id=0.
REQ-037 Carry propagation: req1 with a=0xFFFFFFFF, b=0, cin=1 -> rsp_sum=0x00000000, cout=1, id=1; in the HI cycle add_cin=1.
REQ-038 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows; req0 is first after reset.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, outputs stable, both readys stay 0; accept resumes the cycle after rsp_ready=1.
REQ-040 Reset abort: assert rst_n low during HI for operands 0x12345678+0x0FEDCBA8 -> rsp_valid stays 0 and outputs are 0; the next request after release completes normally.
REQ-041 Random: 1000 random operations with random valid/rsp_ready, compared against a 33-bit reference sum; no lost or duplicated responses.

Source files
------------

// File: rtl/add32_sched.sv
// add32_sched: two-requester scheduler that performs 32-bit additions by
// sequencing a shared external 16-bit combinational adder over two cycles
// (low half, then high half) and presenting the result on a valid/ready port.
module add32_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_id,
  output logic [15:0] add_in1,
  output logic [15:0] add_in2,
  output logic        add_cin,
  input  logic [15:0] add_out,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic        carry_q, carry_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;

  logic        grant_id;
  logic        accept;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Next-state logic and shared-adder operand steering for each phase.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    add_in1      = 16'h0000;
    add_in2      = 16'h0000;
    add_cin      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant_id ? req1_a : req0_a;
          b_d          = grant_id ? req1_b : req0_b;
          cin_d        = grant_id ? req1_cin : req0_cin;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = LO;
        end
      end
      LO: begin
        add_in1      = a_q[15:0];
        add_in2      = b_q[15:0];
        add_cin      = cin_q;
        sum_d[15:0]  = add_out;
        carry_d      = add_cout;
        state_d      = HI;
      end
      HI: begin
        add_in1      = a_q[31:16];
        add_in2      = b_q[31:16];
        add_cin      = carry_q;
        sum_d[31:16] = add_out;
        cout_d       = add_cout;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      carry_q      <= 1'b0;
      sum_q        <= 32'h0;
      cout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      carry_q      <= carry_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_add32_sched.sv
// Directed and random bench for add32_sched, with a behavioural model of the
// shared 16-bit adder and a reference 33-bit sum for every operation.
module tb_add32_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [31:0] rsp_sum;
  logic [15:0] add_in1, add_in2, add_out;
  logic        add_cin, add_cout;
  logic [16:0] addFull;

  int checks = 0;
  int failures = 0;

  add32_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_cin    (add_cin),
    .add_out    (add_out),
    .add_cout   (add_cout)
  );

  // Shared external 16-bit adder.
  assign addFull  = {1'b0, add_in1} + {1'b0, add_in2} + {16'h0000, add_cin};
  assign add_out  = addFull[15:0];
  assign add_cout = addFull[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic c0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic c1, input logic rr);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req0_cin   = c0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    req1_cin   = c1;
    rsp_ready  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [33:0] sb[$];
    logic [33:0] expRsp;
    logic        v0, v1;
    int          issued, received, cyc;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_sum", 64'(rsp_sum), 64'h0);
    checkOutput("reset_rsp_cout", 64'(rsp_cout), 64'h0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'h0);
    checkOutput("reset_add_in", 64'({add_in1, add_in2, add_cin}), 64'h0);

    // Single op from requester 0, accepted in the first cycle after release
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h00010001, 32'h0000FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("single_ready0", 64'(req0_ready), 64'h1);
    checkOutput("single_ready1", 64'(req1_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("single_lo_add", 64'({add_in1, add_in2, add_cin}), 64'({16'h0001, 16'hFFFF, 1'b0}));
    checkOutput("single_lo_valid", 64'(rsp_valid), 64'h0);
    tick();
    checkOutput("single_hi_add", 64'({add_in1, add_in2, add_cin}), 64'({16'h0001, 16'h0000, 1'b1}));
    checkOutput("single_hi_valid", 64'(rsp_valid), 64'h0);
    tick();
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("single_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({1'b0, 1'b0, 32'h00020000}));
    checkOutput("single_rsp_add_idle", 64'({add_in1, add_in2, add_cin}), 64'h0);
    tick();
    checkOutput("single_done_valid", 64'(rsp_valid), 64'h0);

    // Carry propagation through the high half, requester 1
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    #1;
    checkOutput("carry_ready1", 64'(req1_ready), 64'h1);
    checkOutput("carry_ready0", 64'(req0_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("carry_lo_add", 64'({add_in1, add_in2, add_cin}), 64'({16'hFFFF, 16'h0000, 1'b1}));
    tick();
    checkOutput("carry_hi_add", 64'({add_in1, add_in2, add_cin}), 64'({16'hFFFF, 16'h0000, 1'b1}));
    tick();
    checkOutput("carry_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'({1'b1, 1'b1, 1'b1, 32'h00000000}));
    tick();

    // Contention after a fresh reset: grants alternate starting with requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'h00000100, 32'h00000200, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("contend_ready_%0d", k), 64'({req0_ready, req1_ready}),
                  (k % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      tick();
      tick();
      checkOutput($sformatf("contend_rsp_%0d", k), 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}),
                  (k % 2 == 0) ? 64'({1'b1, 1'b0, 1'b0, 32'h00000003})
                               : 64'({1'b1, 1'b1, 1'b0, 32'h00000301}));
      tick();
    end

    // Backpressure: hold the response for five cycles with both requesters waiting
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000005, 32'h00000006, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready0", 64'({req0_ready, req1_ready}), 64'h2);
    tick();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_hold_%0d", k), 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}),
                  64'({1'b1, 1'b0, 1'b0, 32'h80000000}));
      checkOutput($sformatf("bp_readys_%0d", k), 64'({req0_ready, req1_ready}), 64'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_resume_ready1", 64'({req0_ready, req1_ready}), 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("bp_resume_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}),
                64'({1'b1, 1'b1, 1'b0, 32'h0000000B}));
    tick();

    // Reset during HI aborts the operation with no response afterwards
    applyStimulus(1'b1, 32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("abort_in_hi", 64'({add_in1, add_in2}), 64'({16'h1234, 16'h0FED}));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("abort_no_rsp_%0d", k), 64'({rsp_valid, rsp_sum}), 64'h0);
    end
    applyStimulus(1'b1, 32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("abort_next_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}),
                64'({1'b1, 1'b0, 1'b0, 32'h22222220}));
    tick();

    // Random traffic against a 33-bit reference sum
    issued   = 0;
    received = 0;
    cyc      = 0;
    while (received < 1000 && cyc < 30000) begin
      v0 = (issued < 1000) && ($urandom_range(0, 1) == 1);
      v1 = (issued < 1000) && ($urandom_range(0, 1) == 1);
      applyStimulus(v0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    v1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
      #2;
      checkOutput("rand_ready_onehot", 64'(req0_ready & req1_ready), 64'h0);
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, 33'(req0_a) + 33'(req0_b) + 33'(req0_cin)});
        issued++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, 33'(req1_a) + 33'(req1_b) + 33'(req1_cin)});
        issued++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rand_unexpected_rsp", 64'(sb.size()), 64'h1);
        end else begin
          expRsp = sb.pop_front();
          checkOutput("rand_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(expRsp));
        end
        received++;
      end
      tick();
      cyc++;
    end
    checkOutput("rand_received", 64'(received), 64'd1000);
    checkOutput("rand_leftover", 64'(sb.size()), 64'h0);

    $display("[TB] random phase ran %0d cycles", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
